// File: rtl/xnor_reduce_sched.sv
`default_nettype none
// =============================================================================
// xnor_reduce_sched : shared multi-cycle XNOR-reduction engine, round-robin
// arbitrated. Optional macro XNOR_REDUCE_SCHED_CNT_EN adds rsp_cnt. Rev 1.0
// =============================================================================
module xnor_reduce_sched #(
   parameter  int NREQ  = 2,
   parameter  int CHUNK = 32,
   localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*128-1:0] req_data,
   input  logic [NREQ*8-1:0]   req_len,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic                rsp_out,
   output logic                rsp_err,
   output logic                busy
`ifdef XNOR_REDUCE_SCHED_CNT_EN
   ,
   output logic [NREQ*16-1:0]  rsp_cnt
`endif
);

   localparam int c_NCH_MAX = 128 / CHUNK;
   localparam int c_SH      = $clog2(CHUNK);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDW-1:0]   r_ptr;
   logic [IDW-1:0]   r_id;
   logic [127:0]     r_data;
   logic [7:0]       r_len;
   logic [4:0]       r_idx;
   logic [4:0]       r_nch;
   logic             r_acc;
   logic             r_bad;
   logic             r_out;
   logic             r_err;

   logic             w_gnt_any;
   logic [IDW-1:0]   w_gnt_id;
   logic             w_accept;
   logic [127:0]     w_sel_data;
   logic [7:0]       w_sel_len;
   logic             w_bad;
   logic [8:0]       w_sum;
   logic [4:0]       w_nch;
   logic [CHUNK-1:0] w_chunk;
   logic [CHUNK-1:0] w_bits;
   logic [8:0]       w_base;
   logic             w_par;
   logic             w_last;

   // Round-robin search: first pass from the pointer upward, second pass wraps
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_id  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!w_gnt_any && req_valid[i] && (i >= int'(r_ptr))) begin
            w_gnt_any = 1'b1;
            w_gnt_id  = IDW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!w_gnt_any && req_valid[i]) begin
            w_gnt_any = 1'b1;
            w_gnt_id  = IDW'(i);
         end
      end
   end

   always_comb begin
      req_ready  = '0;
      w_sel_data = '0;
      w_sel_len  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt_id == IDW'(i)) begin
            req_ready[i] = rst_n && (r_state == IDLE) && w_gnt_any;
            w_sel_data   = req_data[i*128 +: 128];
            w_sel_len    = req_len[i*8 +: 8];
         end
      end
   end

   assign w_accept = |(req_valid & req_ready);
   assign w_bad    = (w_sel_len == 8'd0) || (w_sel_len > 8'd128);
   assign w_sum    = {1'b0, w_sel_len} + 9'(CHUNK - 1);
   assign w_nch    = 5'(w_sum >> c_SH);

   // Chunk select and length mask: only bit positions below len contribute
   always_comb begin
      w_chunk = '0;
      w_base  = '0;
      w_bits  = '0;
      for (int c = 0; c < c_NCH_MAX; c++) begin
         if (r_idx == 5'(c)) begin
            w_chunk = r_data[c*CHUNK +: CHUNK];
            w_base  = 9'(c * CHUNK);
         end
      end
      for (int j = 0; j < CHUNK; j++) begin
         w_bits[j] = w_chunk[j] & ((w_base + 9'(j)) < {1'b0, r_len});
      end
      w_par = ^w_bits;
   end

   assign w_last = (r_idx == (r_nch - 5'd1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      rsp_valid   = 1'b0;
      busy        = 1'b1;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (w_accept) w_state_nxt = RUN;
         end
         RUN: begin
            if (w_last) w_state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Illegal lengths take one RUN cycle so their response latency matches len=1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr  <= '0;
         r_id   <= '0;
         r_data <= '0;
         r_len  <= '0;
         r_idx  <= '0;
         r_nch  <= '0;
         r_acc  <= 1'b0;
         r_bad  <= 1'b0;
         r_out  <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_data <= w_sel_data;
                  r_len  <= w_sel_len;
                  r_id   <= w_gnt_id;
                  r_acc  <= 1'b0;
                  r_idx  <= '0;
                  r_bad  <= w_bad;
                  r_nch  <= w_bad ? 5'd1 : w_nch;
               end
            end
            RUN: begin
               r_acc <= r_acc ^ w_par;
               r_idx <= r_idx + 5'd1;
               if (w_last) begin
                  r_out <= r_bad ? 1'b0 : ~(r_acc ^ w_par);
                  r_err <= r_bad;
               end
            end
            RESP: begin
               if (rsp_ready) r_ptr <= IDW'((int'(r_id) + 1) % NREQ);
            end
            default: begin
               r_idx <= '0;
            end
         endcase
      end
   end

   assign rsp_id  = r_id;
   assign rsp_out = r_out;
   assign rsp_err = r_err;

`ifdef XNOR_REDUCE_SCHED_CNT_EN
   generate
      for (genvar g = 0; g < NREQ; g++) begin : g_cnt
         logic [15:0] r_cnt;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt <= '0;
            end else if (rsp_valid && rsp_ready && (r_id == IDW'(g)) &&
                         (r_cnt != 16'hFFFF)) begin
               r_cnt <= r_cnt + 16'd1;
            end
         end
         assign rsp_cnt[g*16 +: 16] = r_cnt;
      end
   endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_xnor_reduce_sched.sv
`default_nettype none
// =============================================================================
// tb_xnor_reduce_sched : directed self-checking bench for xnor_reduce_sched
// (NREQ=2, CHUNK=32). Rev 1.0
// =============================================================================
module tb_xnor_reduce_sched;

   logic         clk;
   logic         rst_n;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [255:0] req_data;
   logic [15:0]  req_len;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [0:0]   rsp_id;
   logic         rsp_out;
   logic         rsp_err;
   logic         busy;
`ifdef XNOR_REDUCE_SCHED_CNT_EN
   logic [31:0]  rsp_cnt;
   logic [15:0]  cnt_before;
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic [127:0] ones;

   xnor_reduce_sched #(.NREQ(2), .CHUNK(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_len   (req_len),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_out   (rsp_out),
      .rsp_err   (rsp_err),
      .busy      (busy)
`ifdef XNOR_REDUCE_SCHED_CNT_EN
      ,
      .rsp_cnt   (rsp_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // No grant may be offered while the engine is busy
   always @(negedge clk) begin
      if (rst_n && busy) chk("rdy_busy", 32'(req_ready), 32'd0);
   end

   task automatic xact(input string tag, input int id, input logic [127:0] d,
                       input logic [7:0] l, input logic exp_out, input logic exp_err,
                       input int exp_lat);
      int lat;
      bit got;
      got = 1'b0;
      lat = -1;
      req_data[id*128 +: 128] = d;
      req_len[id*8 +: 8]      = l;
      req_valid[id]           = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready[id]) begin
            got = 1'b1;
            break;
         end
      end
      chk({tag, "_acc"}, 32'(got), 32'd1);
      if (!got) begin
         req_valid[id] = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_valid[id] = 1'b0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         if (j == 0) chk({tag, "_busy"}, 32'(busy), 32'd1);
         if (rsp_valid) begin
            lat = j;
            break;
         end
      end
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_out"}, 32'(rsp_out), 32'(exp_out));
      chk({tag, "_id"},  32'(rsp_id),  32'(id));
      chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
      if (rsp_ready) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit got;
      bit stale;
      ones      = '1;
      rst_n     = 1'b0;
      req_valid = 2'b01;
      req_data  = '0;
      req_len   = '0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_out",   32'(rsp_out),   32'd0);
      chk("rst_id",    32'(rsp_id),    32'd0);
      chk("rst_err",   32'(rsp_err),   32'd0);
      req_valid = 2'b00;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      xact("one128",   0, 128'h1,       8'd128, 1'b0, 1'b0, 4);
      xact("zero1",    0, 128'h0,       8'd1,   1'b1, 1'b0, 1);
      xact("three1",   0, 128'h3,       8'd1,   1'b0, 1'b0, 1);
      xact("three2",   0, 128'h3,       8'd2,   1'b1, 1'b0, 1);
      xact("ones127",  0, ones,         8'd127, 1'b0, 1'b0, 4);
      xact("ones128",  0, ones,         8'd128, 1'b1, 1'b0, 4);
      xact("ff00_8",   0, 128'hFF00,    8'd8,   1'b1, 1'b0, 1);
      xact("ff00_9",   0, 128'hFF00,    8'd9,   1'b0, 1'b0, 1);
      xact("b32_32",   0, 128'h1_0000_0000, 8'd32, 1'b1, 1'b0, 1);
      xact("b32_33",   0, 128'h1_0000_0000, 8'd33, 1'b0, 1'b0, 2);
      xact("r1_seven", 1, 128'h7,       8'd3,   1'b0, 1'b0, 1);

`ifdef XNOR_REDUCE_SCHED_CNT_EN
      cnt_before = rsp_cnt[31:16];
`endif
      xact("len0",     1, ones,         8'd0,   1'b0, 1'b1, 1);
      xact("len129",   1, ones,         8'd129, 1'b0, 1'b1, 1);
`ifdef XNOR_REDUCE_SCHED_CNT_EN
      chk("cnt_err", 32'(rsp_cnt[31:16]), 32'(cnt_before) + 32'd2);
`endif

      // Response held off by rsp_ready with a competing request pending
      rsp_ready = 1'b0;
      xact("hold", 0, 128'h1, 8'd32, 1'b0, 1'b0, 1);
      req_data[128 +: 128] = 128'h0;
      req_len[15:8]        = 8'd1;
      req_valid[1]         = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_v",   32'(rsp_valid), 32'd1);
         chk("hold_out", 32'(rsp_out),   32'd0);
         chk("hold_id",  32'(rsp_id),    32'd0);
         chk("hold_err", 32'(rsp_err),   32'd0);
         chk("hold_rdy", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      @(negedge clk);
      chk("hold_drop", 32'(rsp_valid), 32'd0);

      // Reset during RUN abandons the request
      req_data[0 +: 128] = ones;
      req_len[7:0]       = 8'd128;
      req_valid[0]       = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready[0]) begin
            got = 1'b1;
            break;
         end
      end
      chk("mid_acc", 32'(got), 32'd1);
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_valid", 32'(rsp_valid), 32'd0);
      chk("mid_busy",  32'(busy),      32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      stale = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid) stale = 1'b1;
      end
      chk("mid_stale", 32'(stale), 32'd0);

      // Both requesters held valid: strict alternation starting at 0
      req_data[0 +: 128]   = 128'h1;
      req_len[7:0]         = 8'd1;
      req_data[128 +: 128] = 128'h0;
      req_len[15:8]        = 8'd1;
      req_valid            = 2'b11;
      for (int n = 0; n < 4; n++) begin
         got = 1'b0;
         for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (rsp_valid) begin
               got = 1'b1;
               break;
            end
         end
         chk("rr_valid", 32'(got),     32'd1);
         chk("rr_id",    32'(rsp_id),  32'(n % 2));
         chk("rr_out",   32'(rsp_out), 32'(n % 2));
         @(posedge clk);
         #1;
      end
      req_valid = 2'b00;
      repeat (3) @(negedge clk);
      chk("end_busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
